mem_port_arb: RTL and testbench

Shares the core's single-port instruction/data memory between the instruction-fetch path and the load/store path. Requests from both paths are arbitrated with a load/store-first policy plus a fetch starvation guard. The block then sequences one memory access at a time, with a fixed read latency, and returns data with a one-cycle valid pulse. It sits between the pc/mem_sel address logic and the external memory. This removes the extra load/store phase handling from the control path.

---
 rtl/mem_port_arb.sv | 132 +++++++++++++
 tb/tb_mem_port_arb.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arb.sv
// Arbitrates the fetch and load/store paths onto one single-port memory and
// runs one fixed-latency access at a time, returning data with a valid pulse.
module mem_port_arb #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int LAT        = 1,
   parameter int STARVE_LIM = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                if_req,
   input  logic [ADDR_W-1:0]   if_addr,
   output logic                if_gnt,
   output logic [DATA_W-1:0]   if_rdata,
   output logic                if_valid,
   input  logic                ls_req,
   input  logic                ls_we,
   input  logic [ADDR_W-1:0]   ls_addr,
   input  logic [DATA_W-1:0]   ls_wdata,
   input  logic [DATA_W/8-1:0] ls_be,
   output logic                ls_gnt,
   output logic [DATA_W-1:0]   ls_rdata,
   output logic                ls_valid,
   output logic                mem_en,
   output logic                mem_we,
   output logic [DATA_W/8-1:0] mem_be,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_wdata,
   input  logic [DATA_W-1:0]   mem_rdata,
   output logic                busy
);

   localparam int          BE_W       = DATA_W / 8;
   localparam logic [2:0]  WAIT_LOAD  = 3'(LAT - 1);
   localparam logic [3:0]  STREAK_MAX = 4'(STARVE_LIM);

   typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

   state_t            state, state_nxt;
   logic [2:0]        wcnt;
   logic [3:0]        streak;
   logic              arb_ok, ls_win, if_win;
   logic              cap_owner;   // 1 = load/store owns the access in flight
   logic              cap_we;
   logic [BE_W-1:0]   cap_be;
   logic [ADDR_W-1:0] cap_addr;
   logic [DATA_W-1:0] cap_wdata;

   // Grants are gated by reset so no output can be high while rst is low.
   assign arb_ok = rst && ((state == IDLE) || (state == RESP));
   assign ls_win = arb_ok && ls_req && !(if_req && (streak == STREAK_MAX));
   assign if_win = arb_ok && if_req && !ls_win;

   assign ls_gnt    = ls_win;
   assign if_gnt    = if_win;
   assign mem_en    = (state == ACCESS);
   assign mem_we    = (state == ACCESS) && cap_we;
   assign mem_be    = cap_be;
   assign mem_addr  = cap_addr;
   assign mem_wdata = cap_wdata;
   assign ls_valid  = (state == RESP) && cap_owner;
   assign if_valid  = (state == RESP) && !cap_owner;
   assign busy      = (state != IDLE);

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (ls_win || if_win) state_nxt = ACCESS;
         ACCESS:  state_nxt = WAIT;
         WAIT:    if (wcnt == 3'd0) state_nxt = RESP;
         RESP:    state_nxt = (ls_win || if_win) ? ACCESS : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= IDLE;
         wcnt   <= 3'd0;
         streak <= 4'd0;
      end else begin
         state <= state_nxt;
         if (state == ACCESS)
            wcnt <= WAIT_LOAD;
         else if ((state == WAIT) && (wcnt != 3'd0))
            wcnt <= wcnt - 3'd1;
         // Streak only grows while a fetch is actually being passed over.
         if (ls_win) begin
            if (!if_req)
               streak <= 4'd0;
            else if (streak != STREAK_MAX)
               streak <= streak + 4'd1;
         end else if (if_win) begin
            streak <= 4'd0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cap_owner <= 1'b0;
         cap_we    <= 1'b0;
         cap_be    <= '0;
         cap_addr  <= '0;
         cap_wdata <= '0;
         if_rdata  <= '0;
         ls_rdata  <= '0;
      end else begin
         if (ls_win) begin
            cap_owner <= 1'b1;
            cap_we    <= ls_we;
            cap_be    <= ls_be;
            cap_addr  <= ls_addr;
            cap_wdata <= ls_wdata;
         end else if (if_win) begin
            cap_owner <= 1'b0;
            cap_we    <= 1'b0;
            cap_be    <= '1;
            cap_addr  <= if_addr;
            cap_wdata <= '0;
         end
         // Read data lands in the owner's register on the last WAIT cycle.
         if ((state == WAIT) && (wcnt == 3'd0) && !cap_we) begin
            if (cap_owner)
               ls_rdata <= mem_rdata;
            else
               if_rdata <= mem_rdata;
         end
      end
   end

endmodule

// File: tb/tb_mem_port_arb.sv
// Directed bench for mem_port_arb: a LAT=1 instance for most steps and a
// LAT=3 instance sharing the same inputs for the long-latency load.
module tb_mem_port_arb;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req, ls_req, ls_we;
   logic [31:0] if_addr, ls_addr, ls_wdata, mem_rdata;
   logic [3:0]  ls_be;

   logic        if_gnt, if_valid, ls_gnt, ls_valid, mem_en, mem_we, busy;
   logic [31:0] if_rdata, ls_rdata, mem_addr, mem_wdata;
   logic [3:0]  mem_be;

   logic        if_gnt_3, if_valid_3, ls_gnt_3, ls_valid_3, mem_en_3, mem_we_3, busy_3;
   logic [31:0] if_rdata_3, ls_rdata_3, mem_addr_3, mem_wdata_3;
   logic [3:0]  mem_be_3;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   mem_port_arb #(.ADDR_W(32), .DATA_W(32), .LAT(1), .STARVE_LIM(4)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rdata(if_rdata), .if_valid(if_valid),
      .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_be(ls_be),
      .ls_gnt(ls_gnt), .ls_rdata(ls_rdata), .ls_valid(ls_valid),
      .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
   );

   mem_port_arb #(.ADDR_W(32), .DATA_W(32), .LAT(3), .STARVE_LIM(4)) dut3 (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt_3), .if_rdata(if_rdata_3), .if_valid(if_valid_3),
      .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_be(ls_be),
      .ls_gnt(ls_gnt_3), .ls_rdata(ls_rdata_3), .ls_valid(ls_valid_3),
      .mem_en(mem_en_3), .mem_we(mem_we_3), .mem_be(mem_be_3), .mem_addr(mem_addr_3),
      .mem_wdata(mem_wdata_3), .mem_rdata(mem_rdata), .busy(busy_3)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b0; if_req = 1'b1; ls_req = 1'b0; ls_we = 1'b0;
      if_addr = 32'h0; ls_addr = 32'h0; ls_wdata = 32'h0; ls_be = 4'h0;
      mem_rdata = 32'h0;
      #2;
      chk("rst_if_gnt", if_gnt, 0);
      chk("rst_busy", busy, 0);
      chk("rst_mem_en", mem_en, 0);
      chk("rst_mem_be", mem_be, 0);
      chk("rst_if_rdata", if_rdata, 0);
      chk("rst_ls_rdata", ls_rdata, 0);
      if_req = 1'b0;
      tick(); tick();
      rst = 1'b1;

      // Single fetch, LAT=1
      tick();
      if_req = 1'b1; if_addr = 32'h100; mem_rdata = 32'h0050_0093;
      #1;
      chk("t1_if_gnt", if_gnt, 1);
      chk("t1_ls_gnt", ls_gnt, 0);
      tick(); if_req = 1'b0; #1;
      chk("t1_mem_en", mem_en, 1);
      chk("t1_mem_addr", mem_addr, 32'h100);
      chk("t1_mem_we", mem_we, 0);
      chk("t1_mem_be", mem_be, 4'hF);
      chk("t1_busy1", busy, 1);
      tick(); #1;
      chk("t1_wait_en", mem_en, 0);
      chk("t1_wait_valid", if_valid, 0);
      chk("t1_busy2", busy, 1);
      tick(); #1;
      chk("t1_if_valid", if_valid, 1);
      chk("t1_if_rdata", if_rdata, 32'h0050_0093);
      chk("t1_busy3", busy, 1);
      tick(); #1;
      chk("t1_idle_busy", busy, 0);
      chk("t1_valid_drop", if_valid, 0);
      chk("t1_rdata_hold", if_rdata, 32'h0050_0093);

      // Store
      tick();
      ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h2004; ls_wdata = 32'hDEAD_BEEF; ls_be = 4'b0011;
      mem_rdata = 32'hAAAA_AAAA;
      #1;
      chk("t2_ls_gnt", ls_gnt, 1);
      tick(); ls_req = 1'b0; ls_we = 1'b0; ls_wdata = 32'h0; ls_be = 4'h0; #1;
      chk("t2_mem_en", mem_en, 1);
      chk("t2_mem_we", mem_we, 1);
      chk("t2_mem_be", mem_be, 4'b0011);
      chk("t2_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
      chk("t2_mem_addr", mem_addr, 32'h2004);
      tick(); #1;
      chk("t2_wait_we", mem_we, 0);
      tick(); #1;
      chk("t2_ls_valid", ls_valid, 1);
      chk("t2_if_valid", if_valid, 0);
      chk("t2_ls_rdata", ls_rdata, 0);
      chk("t2_wdata_hold", mem_wdata, 32'hDEAD_BEEF);
      tick(); #1;
      chk("t2_idle", busy, 0);

      // Conflict with starvation guard
      tick();
      if_req = 1'b1; if_addr = 32'h80; ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h40;
      mem_rdata = 32'h1111_2222;
      #1;
      for (int g = 0; g < 10; g++) begin
         chk($sformatf("t3_ls_gnt%0d", g), ls_gnt, (g == 4 || g == 9) ? 1'b0 : 1'b1);
         chk($sformatf("t3_if_gnt%0d", g), if_gnt, (g == 4 || g == 9) ? 1'b1 : 1'b0);
         if (g > 0)
            chk($sformatf("t3_ls_valid%0d", g), ls_valid, (g == 5) ? 1'b0 : 1'b1);
         if (g < 9) begin
            tick(); #1;
            chk($sformatf("t3_quiet_a%0d", g), {if_gnt, ls_gnt}, 2'b00);
            tick(); #1;
            chk($sformatf("t3_quiet_b%0d", g), {if_gnt, ls_gnt}, 2'b00);
            tick(); #1;
         end
      end
      tick(); if_req = 1'b0; ls_req = 1'b0; #1;
      chk("t3_last_addr", mem_addr, 32'h80);
      tick(); tick(); #1;
      chk("t3_if_valid", if_valid, 1);
      chk("t3_if_rdata", if_rdata, 32'h1111_2222);
      chk("t3_ls_rdata", ls_rdata, 32'h1111_2222);
      tick(); #1;
      chk("t3_idle", busy, 0);

      // Back-to-back load in the RESP cycle
      tick();
      ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h500; mem_rdata = 32'h0BAD_F00D;
      #1;
      chk("t6_gnt1", ls_gnt, 1);
      tick(); ls_req = 1'b0; #1;
      tick(); tick();
      ls_req = 1'b1; ls_addr = 32'h504;
      #1;
      chk("t6_ls_valid", ls_valid, 1);
      chk("t6_ls_gnt", ls_gnt, 1);
      chk("t6_ls_rdata", ls_rdata, 32'h0BAD_F00D);
      tick(); ls_req = 1'b0; #1;
      chk("t6_mem_en", mem_en, 1);
      chk("t6_mem_addr", mem_addr, 32'h504);
      tick(); tick(); #1;
      chk("t6_ls_valid2", ls_valid, 1);
      tick(); #1;
      chk("t6_idle", busy, 0);

      // Reset in the middle of WAIT
      tick();
      if_req = 1'b1; if_addr = 32'h600; mem_rdata = 32'h0000_7777;
      #1;
      chk("t5_gnt", if_gnt, 1);
      tick(); if_req = 1'b0;
      tick(); #1;
      chk("t5_in_wait", {busy, mem_en}, 2'b10);
      #1;
      rst = 1'b0; if_addr = 32'h700; if_req = 1'b1;
      #1;
      chk("t5_busy_rst", busy, 0);
      chk("t5_addr_rst", mem_addr, 0);
      chk("t5_be_rst", mem_be, 0);
      chk("t5_rdata_rst", {if_rdata, ls_rdata}, 64'h0);
      chk("t5_gnt_in_rst", if_gnt, 0);
      tick();
      chk("t5_no_valid", {if_valid, ls_valid, busy}, 3'b000);
      rst = 1'b1;
      #1;
      chk("t5_gnt_after", if_gnt, 1);
      tick(); if_req = 1'b0; #1;
      chk("t5_mem_en", mem_en, 1);
      chk("t5_mem_addr", mem_addr, 32'h700);
      tick(); tick(); #1;
      chk("t5_if_valid", if_valid, 1);
      chk("t5_if_rdata", if_rdata, 32'h0000_7777);
      repeat (8) tick();

      // LAT=3 load on the second instance, fetch pending throughout
      chk("t4_idle", busy_3, 0);
      ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h3000;
      if_req = 1'b1; if_addr = 32'h3100; mem_rdata = 32'h1234_5678;
      #1;
      chk("t4_ls_gnt", ls_gnt_3, 1);
      chk("t4_if_gnt", if_gnt_3, 0);
      tick(); ls_req = 1'b0; #1;
      chk("t4_mem_en", mem_en_3, 1);
      chk("t4_mem_addr", mem_addr_3, 32'h3000);
      chk("t4_quiet1", {if_gnt_3, ls_gnt_3}, 2'b00);
      for (int c = 2; c <= 4; c++) begin
         tick(); #1;
         chk($sformatf("t4_quiet%0d", c), {if_gnt_3, ls_gnt_3, mem_en_3, ls_valid_3}, 4'b0000);
      end
      tick(); #1;
      chk("t4_ls_valid", ls_valid_3, 1);
      chk("t4_ls_rdata", ls_rdata_3, 32'h1234_5678);
      chk("t4_if_gnt_resp", if_gnt_3, 1);
      tick(); if_req = 1'b0;
      repeat (6) tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout: bench did not complete");
      $fatal(1, "timeout");
   end

endmodule
